// File: rtl/mult_pipe_pkg.sv
// Shared types and helpers for the pipelined parity-checked multiplier.
package mult_pipe_pkg;

  localparam int unsigned MAX_WIDTH = 32;
  localparam int unsigned PROD_W    = 2 * MAX_WIDTH;

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } mode_e;

  // Product is sized for the widest legal operand; narrower instances zero-extend.
  typedef struct packed {
    logic [PROD_W-1:0] product;
    logic              parity;
    logic              error;
  } entry_t;

  function automatic logic even_parity(input logic [PROD_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/mult_pipe_fifo.sv
// Result buffer: power-of-two circular FIFO with fall-through when empty.
module mult_pipe_fifo #(
  parameter  int unsigned DW    = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          rd_i,
  output logic [DW-1:0] rdata_o,
  output logic          rdy_o,
  output logic [CW-1:0] count_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          empty_c;
  logic          pop_c;

  // An incoming write is visible as head when empty, so write+pop at count 0 passes through.
  assign empty_c = (count_q == '0);
  assign rdy_o   = !empty_c || wr_i;
  assign pop_c   = rd_i && rdy_o;
  assign rdata_o = empty_c ? wdata_i : mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_i) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_c) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_i && !pop_c) begin
      count_d = count_q + CW'(1);
    end else if (!wr_i && pop_c) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mult_pipe.sv
// Pipelined signed/unsigned multiplier with operand parity check and
// credit-based flow control into a result buffer.
module mult_pipe
  import mult_pipe_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned STAGES     = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req,
  output logic               ack,
  input  logic [WIDTH-1:0]   arg_a,
  input  logic [WIDTH-1:0]   arg_b,
  input  logic               arg_a_parity,
  input  logic               arg_b_parity,
  input  logic               signed_mode,
  input  logic               result_rd,
  output logic               result_rdy,
  output logic [2*WIDTH-1:0] result,
  output logic               result_parity,
  output logic               arg_parity_error
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW = $bits(entry_t);

  mode_e             mode_c;
  logic              accept_c;
  logic              bad_par_c;
  logic [PW-1:0]     a_ext_c, b_ext_c, prod_c;
  entry_t            ent_c;
  logic [STAGES-1:0] vld_q, vld_d;
  entry_t            ent_q [STAGES];
  entry_t            ent_d [STAGES];
  logic [CW-1:0]     inflight_q, inflight_d;
  logic [CW-1:0]     count_c;
  logic              wr_c;
  logic              rdy_c;
  entry_t            head_c;

  // Credit: every accepted op already owns a buffer slot, so nothing is ever dropped.
  assign ack      = rst_n && ((CW + 1)'(count_c) + (CW + 1)'(inflight_q) < (CW + 1)'(FIFO_DEPTH));
  assign accept_c = req && ack;
  assign wr_c     = vld_q[STAGES-1];
  assign mode_c   = mode_e'(signed_mode);

  always_comb begin
    a_ext_c   = PW'(arg_a);
    b_ext_c   = PW'(arg_b);
    if (mode_c == MODE_SIGNED) begin
      a_ext_c = {{WIDTH{arg_a[WIDTH-1]}}, arg_a};
      b_ext_c = {{WIDTH{arg_b[WIDTH-1]}}, arg_b};
    end
    prod_c    = a_ext_c * b_ext_c;
    bad_par_c = (even_parity(PROD_W'(arg_a)) != arg_a_parity) ||
                (even_parity(PROD_W'(arg_b)) != arg_b_parity);
    ent_c.product = bad_par_c ? '0 : PROD_W'(prod_c);
    ent_c.parity  = bad_par_c ? 1'b0 : even_parity(PROD_W'(prod_c));
    ent_c.error   = bad_par_c;
  end

  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = accept_c;
    ent_d[0] = ent_c;
    for (int unsigned i = 1; i < STAGES; i++) ent_d[i] = ent_q[i-1];
  end

  always_comb begin
    inflight_d = inflight_q;
    if (accept_c && !wr_c) begin
      inflight_d = inflight_q + CW'(1);
    end else if (!accept_c && wr_c) begin
      inflight_d = inflight_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q      <= '0;
      inflight_q <= '0;
    end else begin
      vld_q      <= vld_d;
      inflight_q <= inflight_d;
    end
  end

  // Payload is qualified by vld_q and needs no reset.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < STAGES; i++) ent_q[i] <= ent_d[i];
  end

  mult_pipe_fifo #(
    .DW   (EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_i   (wr_c),
    .wdata_i(ent_q[STAGES-1]),
    .rd_i   (result_rd),
    .rdata_o(head_c),
    .rdy_o  (rdy_c),
    .count_o(count_c)
  );

  assign result_rdy       = rdy_c;
  assign result           = rdy_c ? PW'(head_c.product) : '0;
  assign result_parity    = rdy_c && head_c.parity;
  assign arg_parity_error = rdy_c && head_c.error;

endmodule

// File: tb/tb_mult_pipe.sv
// Scoreboard bench for mult_pipe: expected products queued at acceptance,
// compared in order as results are popped.
module tb_mult_pipe;

  localparam int unsigned W  = 16;
  localparam int unsigned ST = 3;
  localparam int unsigned FD = 4;

  typedef struct packed {
    logic [2*W-1:0] res;
    logic           par;
    logic           err;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst_n, req, ack, pa, pb, sm, rd, rdy, rpar, rerr;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] res;

  exp_t           q[$];
  int             n_cmp = 0, n_bad = 0;
  int             cyc = 0, acc_cyc = -1, rdy_cyc = -1;
  int             n_acc = 0, n_nack = 0, n_pop = 0;
  logic [2*W-1:0] last_res;
  logic           last_par, last_err;

  always #5 clk = ~clk;

  mult_pipe #(.WIDTH(W), .STAGES(ST), .FIFO_DEPTH(FD)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req             (req),
    .ack             (ack),
    .arg_a           (a),
    .arg_b           (b),
    .arg_a_parity    (pa),
    .arg_b_parity    (pb),
    .signed_mode     (sm),
    .result_rd       (rd),
    .result_rdy      (rdy),
    .result          (res),
    .result_parity   (rpar),
    .arg_parity_error(rerr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic gp(input logic [W-1:0] x);
    return ^x;
  endfunction

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic px, input logic py, input logic s);
    longint xa, ya, p;
    exp_t   e;
    xa    = s ? longint'($signed(x)) : longint'(x);
    ya    = s ? longint'($signed(y)) : longint'(y);
    p     = xa * ya;
    e.err = (gp(x) != px) || (gp(y) != py);
    e.res = e.err ? '0 : p[2*W-1:0];
    e.par = ^e.res;
    return e;
  endfunction

  // Drive one cycle's inputs at the falling edge, then judge what the next rising edge will do.
  task automatic cycle(input logic rq, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic px, input logic py, input logic s, input logic rdi);
    exp_t e;
    @(negedge clk);
    req = rq; a = x; b = y; pa = px; pb = py; sm = s; rd = rdi;
    #1;
    cyc++;
    if (rdy && rdy_cyc < 0) rdy_cyc = cyc;
    if (rst_n && rq) begin
      if (ack) begin
        q.push_back(model(x, y, px, py, s));
        n_acc++;
        acc_cyc = cyc;
      end else begin
        n_nack++;
      end
    end
    if (!rdy) begin
      check("idle_out", 64'({res, rpar, rerr}), 64'(0));
    end else if (rst_n && rdi) begin
      if (q.size() == 0) begin
        check("stale_rdy", 64'(rdy), 64'(0));
      end else begin
        e = q.pop_front();
        n_pop++;
        last_res = res; last_par = rpar; last_err = rerr;
        check("result", 64'(res), 64'(e.res));
        check("parity", 64'(rpar), 64'(e.par));
        check("par_err", 64'(rerr), 64'(e.err));
      end
    end
  endtask

  task automatic idle(input logic rdi);
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, rdi);
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input logic rdi);
    cycle(1'b1, x, y, gp(x), gp(y), s, rdi);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b0; req = 1'b0; rd = 1'b0;
      #1;
      check("ack_in_rst", 64'(ack), 64'(0));
      if (i > 0) check("out_in_rst", 64'({rdy, res, rpar, rerr}), 64'(0));
    end
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ack_after_rst", 64'(ack), 64'(1));
    check("out_after_rst", 64'({rdy, res, rpar, rerr}), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; rd = 1'b0; a = '0; b = '0; pa = 1'b0; pb = 1'b0; sm = 1'b0;
    do_reset(3);

    // Unsigned max square and first-result latency
    rdy_cyc = -1;
    op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) idle(1'b1);
    check("latency", 64'(rdy_cyc - acc_cyc), 64'(ST));
    check("ffff_sq", 64'(last_res), 64'h0000_0000_FFFE_0001);
    check("ffff_par", 64'(last_par), 64'(0));
    check("ffff_err", 64'(last_err), 64'(0));

    // Same operands in both modes
    op(16'hFFFE, 16'h0003, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) idle(1'b1);
    check("signed_m2x3", 64'(last_res), 64'h0000_0000_FFFF_FFFA);
    op(16'hFFFE, 16'h0003, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) idle(1'b1);
    check("unsigned_fffex3", 64'(last_res), 64'h0000_0000_0002_FFFA);

    // Bad operand parity followed by a clean op
    cycle(1'b1, 16'h0001, 16'h1234, 1'b0, gp(16'h1234), 1'b0, 1'b1);
    op(16'h0003, 16'h0005, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) idle(1'b1);
    check("after_bad_res", 64'(last_res), 64'd15);

    // Backpressure: buffer fills, one pop releases exactly one credit
    n_acc = 0; n_pop = 0;
    for (int i = 0; i < 8; i++) begin
      op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end
    check("bp_accepts", 64'(n_acc), 64'(FD));
    check("bp_ack_low", 64'(ack), 64'(0));
    op(W'($urandom), W'($urandom), 1'b1, 1'b1);
    check("bp_no_accept_on_pop", 64'(n_acc), 64'(FD));
    op(W'($urandom), W'($urandom), 1'b0, 1'b0);
    check("bp_one_more", 64'(n_acc), 64'(FD + 1));
    for (int i = 0; i < 12; i++) idle(1'b1);
    check("bp_pops", 64'(n_pop), 64'(FD + 1));
    check("bp_drained", 64'(q.size()), 64'(0));

    // Streaming with continuous reads, occasional bad parity
    n_acc = 0; n_nack = 0; n_pop = 0;
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] x, y;
      x = W'($urandom); y = W'($urandom);
      cycle(1'b1, x, y, gp(x) ^ (i % 7 == 3), gp(y), 1'($urandom_range(0, 1)), 1'b1);
    end
    check("stream_nack", 64'(n_nack), 64'(0));
    check("stream_accepts", 64'(n_acc), 64'(20));
    for (int i = 0; i < 10; i++) idle(1'b1);
    check("stream_pops", 64'(n_pop), 64'(20));

    // Reset with two buffered and two in flight
    for (int i = 0; i < 4; i++) op(W'($urandom), W'($urandom), 1'b0, 1'b0);
    idle(1'b0);
    check("pre_rst_rdy", 64'(rdy), 64'(1));
    do_reset(1);
    n_pop = 0;
    for (int i = 0; i < 8; i++) idle(1'b1);
    check("post_rst_pops", 64'(n_pop), 64'(0));
    op(16'h0102, 16'h0304, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) idle(1'b1);
    check("post_rst_op", 64'(last_res), 64'h0000_0000_0003_0A08);
    check("final_empty", 64'(q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
